// File: rtl/mofu_pkg.sv
// Shared definitions for the transaction ingress path: widths, frame geometry
// and the ingress FSM state type.
package mofu_pkg;

    localparam int TXN_W         = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_TXN = 4;
    localparam int IDX_W         = $clog2(WORDS_PER_TXN);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } ingress_state_e;

    // True when the word index points at the final word slot of a frame.
    function automatic logic is_final_slot(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(WORDS_PER_TXN - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags. The head entry is read
// combinationally so that a pop decision can be registered straight into the
// consumer's output register in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage array: no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/txn_ingress.sv
// Transaction ingress: assembles 4-word frames into 128-bit transactions,
// flags malformed frames, buffers good transactions in a FIFO and emits them
// as single-cycle pulses separated by at least OUT_GAP idle cycles.
// Optional feature macro: TXN_INGRESS_STATS_EN adds saturating o_txn_cnt and
// o_err_cnt counters.
module txn_ingress
    import mofu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              o_valid,
    output logic [TXN_W-1:0]  o_transaction,
`ifdef TXN_INGRESS_STATS_EN
    output logic [31:0]       o_txn_cnt,
    output logic [15:0]       o_err_cnt,
`endif
    output logic              o_frame_err
);

    localparam int GAP_W = (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(OUT_GAP);

    ingress_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    // part_q[0] holds the first word of the frame in progress.
    logic [WORDS_PER_TXN-2:0][WORD_W-1:0] part_q, part_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [TXN_W-1:0] txn_q, txn_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             accept, push, pop;
    logic             fifo_full, fifo_empty;
    logic [TXN_W-1:0] fifo_head, push_data;

    // Ready is forced low while reset is held; DRAIN always swallows words.
    assign s_ready   = !rst && ((state_q == ST_DRAIN) || !fifo_full);
    assign accept    = s_valid && s_ready;
    assign push_data = {part_q[0], part_q[1], part_q[2], s_data};

    assign o_valid       = valid_q;
    assign o_transaction = txn_q;
    assign o_frame_err   = err_q;

    sync_fifo #(
        .WIDTH (TXN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame assembly FSM: next state, word index, partial words, error and push.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        part_d  = part_q;
        err_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (is_final_slot(idx_q)) begin
                        idx_d = '0;
                        if (s_last) begin
                            push = 1'b1;
                        end else begin
                            // Over-long frame: flag now, drop words until its s_last.
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        part_d[idx_q] = s_data;
                        if (s_last) begin
                            err_d = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_last) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    // Output pacing: pop when data is waiting and the gap counter has expired.
    always_comb begin
        pop     = !fifo_empty && (gap_q == '0);
        valid_d = pop;
        txn_d   = pop ? fifo_head : txn_q;
        if (pop) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            part_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            txn_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            txn_q   <= txn_d;
            gap_q   <= gap_d;
        end
    end

`ifdef TXN_INGRESS_STATS_EN
    logic [31:0] txn_cnt_q, txn_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign o_txn_cnt = txn_cnt_q;
    assign o_err_cnt = err_cnt_q;

    // Saturating event counters for emitted transactions and malformed frames.
    always_comb begin
        txn_cnt_d = (valid_q && (txn_cnt_q != '1)) ? txn_cnt_q + 32'd1 : txn_cnt_q;
        err_cnt_d = (err_q && (err_cnt_q != '1)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_txn_ingress.sv
// Directed self-checking bench for txn_ingress. Two instances share clock and
// reset: dut_a (OUT_GAP=3) covers framing, latency and pacing; dut_b
// (OUT_GAP=30) drains slowly enough for the FIFO to fill.
module tb_txn_ingress;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid_a, s_ready_a, s_last_a, o_valid_a, o_frame_err_a;
    logic [31:0]  s_data_a;
    logic [127:0] o_transaction_a;
    logic         s_valid_b, s_ready_b, s_last_b, o_valid_b, o_frame_err_b;
    logic [31:0]  s_data_b;
    logic [127:0] o_transaction_b;
`ifdef TXN_INGRESS_STATS_EN
    logic [31:0]  o_txn_cnt_a, o_txn_cnt_b;
    logic [15:0]  o_err_cnt_a, o_err_cnt_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int words_acc = 0;
    int first_stall = -1;

    logic [127:0] qa_data[$];
    int           qa_cyc[$];
    logic [127:0] qb_data[$];
    int           qb_cyc[$];
    int erra_n = 0, erra_cyc = -1, errb_n = 0;

    txn_ingress #(.FIFO_DEPTH(4), .OUT_GAP(3)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .s_data(s_data_a), .s_last(s_last_a), .o_valid(o_valid_a),
        .o_transaction(o_transaction_a),
`ifdef TXN_INGRESS_STATS_EN
        .o_txn_cnt(o_txn_cnt_a), .o_err_cnt(o_err_cnt_a),
`endif
        .o_frame_err(o_frame_err_a)
    );

    txn_ingress #(.FIFO_DEPTH(4), .OUT_GAP(30)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_data(s_data_b), .s_last(s_last_b), .o_valid(o_valid_b),
        .o_transaction(o_transaction_b),
`ifdef TXN_INGRESS_STATS_EN
        .o_txn_cnt(o_txn_cnt_b), .o_err_cnt(o_err_cnt_b),
`endif
        .o_frame_err(o_frame_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_valid_a) begin qa_data.push_back(o_transaction_a); qa_cyc.push_back(cyc); end
        if (o_frame_err_a) begin erra_n++; erra_cyc = cyc; end
        if (o_valid_b) begin qb_data.push_back(o_transaction_b); qb_cyc.push_back(cyc); end
        if (o_frame_err_b) errb_n++;
    end

    function automatic logic [31:0] wd(input int k, input int i);
        return 32'hA000_0000 + 32'(k * 256) + 32'(i);
    endfunction

    function automatic logic [127:0] exp_txn(input int k);
        return {wd(k, 0), wd(k, 1), wd(k, 2), wd(k, 3)};
    endfunction

    task automatic send_word(input int sel, input logic [31:0] d, input logic l);
        bit ok = 0;
        if (sel == 0) begin s_valid_a = 1; s_data_a = d; s_last_a = l; end
        else          begin s_valid_b = 1; s_data_b = d; s_last_b = l; end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ((sel == 0) ? s_ready_a : s_ready_b) begin
                ok = 1;
                last_acc = cyc;
                break;
            end else if (first_stall < 0) begin
                first_stall = words_acc;
            end
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin s_valid_a = 0; s_last_a = 0; end
        else          begin s_valid_b = 0; s_last_b = 0; end
        if (ok) words_acc++;
        else begin
            checks++; errors++;
            $display("FAIL send_word_timeout: s_ready never high, got 0 want 1 (sel=%0d)", sel);
        end
    endtask

    task automatic send_frame(input int sel, input int k);
        for (int i = 0; i < 4; i++) send_word(sel, wd(k, i), i == 3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        qa_data.delete(); qa_cyc.delete(); qb_data.delete(); qb_cyc.delete();
        erra_n = 0; erra_cyc = -1; errb_n = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        #1 rst = 1;
        #1;
        checks++; if (s_ready_a !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready_a); end
        checks++; if (o_valid_a !== 1'b0) begin errors++; $display("FAIL rst_o_valid: got %b want 0", o_valid_a); end
        checks++; if (o_frame_err_a !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", o_frame_err_a); end
        checks++; if (o_transaction_a !== 128'h0) begin errors++; $display("FAIL rst_txn: got %h want 0", o_transaction_a); end
`ifdef TXN_INGRESS_STATS_EN
        checks++; if (o_txn_cnt_a !== 32'd0 || o_err_cnt_a !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", o_txn_cnt_a, o_err_cnt_a); end
`endif
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", s_ready_a); end
        idle(1);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int acc4;
        logic [127:0] exp;
        exp = 128'h11111111_22222222_33333333_44444444;
        clear_mon();
        send_word(0, 32'h11111111, 0);
        send_word(0, 32'h22222222, 0);
        send_word(0, 32'h33333333, 0);
        send_word(0, 32'h44444444, 1);
        acc4 = last_acc;
        idle(10);
        checks++; if (qa_data.size() != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", qa_data.size()); end
        else begin
            checks++; if (qa_data[0] !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", qa_data[0], exp); end
            checks++; if (qa_cyc[0] != acc4 + 2) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", qa_cyc[0], acc4 + 2); end
        end
        checks++; if (erra_n != 0) begin errors++; $display("FAIL basic_no_err: got %0d want 0", erra_n); end
        checks++; if (o_valid_a !== 1'b0 || o_transaction_a !== exp) begin errors++; $display("FAIL basic_hold: got %b/%h want 0/%h", o_valid_a, o_transaction_a, exp); end
        $display("test_basic: txn out at cycle offset %0d", (qa_cyc.size() > 0) ? qa_cyc[0] - acc4 : -1);
    endtask

    task automatic test_short_frame();
        int acc2;
        clear_mon();
        send_word(0, wd(2, 8), 0);
        send_word(0, wd(2, 9), 1);
        acc2 = last_acc;
        send_frame(0, 3);
        idle(10);
        checks++; if (erra_n != 1) begin errors++; $display("FAIL short_err_count: got %0d want 1", erra_n); end
        checks++; if (erra_cyc != acc2 + 1) begin errors++; $display("FAIL short_err_cycle: got %0d want %0d", erra_cyc, acc2 + 1); end
        checks++; if (qa_data.size() != 1) begin errors++; $display("FAIL short_count: got %0d want 1", qa_data.size()); end
        else begin
            checks++; if (qa_data[0] !== exp_txn(3)) begin errors++; $display("FAIL short_data: got %h want %h", qa_data[0], exp_txn(3)); end
        end
        $display("test_short_frame: errs=%0d txns=%0d", erra_n, qa_data.size());
    endtask

    task automatic test_long_frame();
        int acc4;
        clear_mon();
        for (int i = 0; i < 4; i++) send_word(0, wd(4, i), 0);
        acc4 = last_acc;
        send_word(0, wd(4, 4), 1);
        send_frame(0, 5);
        idle(10);
        checks++; if (erra_n != 1) begin errors++; $display("FAIL long_err_count: got %0d want 1", erra_n); end
        checks++; if (erra_cyc != acc4 + 1) begin errors++; $display("FAIL long_err_cycle: got %0d want %0d", erra_cyc, acc4 + 1); end
        checks++; if (qa_data.size() != 1) begin errors++; $display("FAIL long_count: got %0d want 1", qa_data.size()); end
        else begin
            checks++; if (qa_data[0] !== exp_txn(5)) begin errors++; $display("FAIL long_data: got %h want %h", qa_data[0], exp_txn(5)); end
        end
        $display("test_long_frame: errs=%0d txns=%0d", erra_n, qa_data.size());
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int k = 10; k < 16; k++) send_frame(0, k);
        idle(20);
        checks++; if (qa_data.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", qa_data.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (qa_data[i] !== exp_txn(10 + i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, qa_data[i], exp_txn(10 + i)); end
                if (i > 0) begin
                    checks++; if (qa_cyc[i] - qa_cyc[i-1] != 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, qa_cyc[i] - qa_cyc[i-1]); end
                end
            end
        end
        checks++; if (erra_n != 0) begin errors++; $display("FAIL b2b_no_err: got %0d want 0", erra_n); end
        $display("test_back_to_back: txns=%0d", qa_data.size());
    endtask

    task automatic test_fifo_full();
        clear_mon();
        words_acc = 0;
        first_stall = -1;
        for (int k = 20; k < 26; k++) send_frame(1, k);
        idle(200);
        checks++; if (first_stall != 20) begin errors++; $display("FAIL full_stall_point: got %0d words want 20", first_stall); end
        checks++; if (qb_data.size() != 6) begin errors++; $display("FAIL full_count: got %0d want 6", qb_data.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (qb_data[i] !== exp_txn(20 + i)) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, qb_data[i], exp_txn(20 + i)); end
                if (i > 0) begin
                    checks++; if (qb_cyc[i] - qb_cyc[i-1] != 31) begin errors++; $display("FAIL full_spacing[%0d]: got %0d want 31", i, qb_cyc[i] - qb_cyc[i-1]); end
                end
            end
        end
        $display("test_fifo_full: stall after %0d words, txns=%0d", first_stall, qb_data.size());
    endtask

    task automatic test_reset_mid();
        int acc4;
        clear_mon();
        for (int k = 30; k < 33; k++) send_frame(1, k);
        send_word(1, wd(33, 0), 0);
        send_word(1, wd(33, 1), 0);
        checks++; if (qb_data.size() != 1) begin errors++; $display("FAIL rmid_pre_count: got %0d want 1", qb_data.size()); end
        rst = 1;
        #1;
        checks++; if (s_ready_b !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b want 0", s_ready_b); end
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++; if (s_ready_b !== 1'b1) begin errors++; $display("FAIL rmid_ready_release: got %b want 1", s_ready_b); end
        idle(40);
        checks++; if (qb_data.size() != 0) begin errors++; $display("FAIL rmid_no_valid: got %0d want 0", qb_data.size()); end
        checks++; if (errb_n != 0) begin errors++; $display("FAIL rmid_no_err: got %0d want 0", errb_n); end
        send_frame(1, 34);
        acc4 = last_acc;
        idle(10);
        checks++; if (qb_data.size() != 1) begin errors++; $display("FAIL rmid_fresh_count: got %0d want 1", qb_data.size()); end
        else begin
            checks++; if (qb_data[0] !== exp_txn(34)) begin errors++; $display("FAIL rmid_fresh_data: got %h want %h", qb_data[0], exp_txn(34)); end
            checks++; if (qb_cyc[0] != acc4 + 2) begin errors++; $display("FAIL rmid_fresh_latency: got %0d want %0d", qb_cyc[0], acc4 + 2); end
        end
        $display("test_reset_mid: fresh txns=%0d", qb_data.size());
    endtask

`ifdef TXN_INGRESS_STATS_EN
    task automatic test_stats();
        send_frame(0, 40);
        send_word(0, wd(41, 0), 1);
        send_frame(0, 42);
        send_word(0, wd(43, 0), 0);
        send_word(0, wd(43, 1), 1);
        send_frame(0, 44);
        idle(20);
        checks++; if (o_txn_cnt_a !== 32'd3) begin errors++; $display("FAIL stats_txn_cnt: got %0d want 3", o_txn_cnt_a); end
        checks++; if (o_err_cnt_a !== 16'd2) begin errors++; $display("FAIL stats_err_cnt: got %0d want 2", o_err_cnt_a); end
        $display("test_stats: txn_cnt=%0d err_cnt=%0d", o_txn_cnt_a, o_err_cnt_a);
    endtask
`endif

    initial begin
        s_valid_a = 0; s_data_a = '0; s_last_a = 0;
        s_valid_b = 0; s_data_b = '0; s_last_b = 0;
        test_reset();
        test_basic();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
`ifdef TXN_INGRESS_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
